// File: rtl/bcd_sub_serial.sv
// -----------------------------------------------------------------------------
// bcd_sub_serial
//   Digit-serial packed-BCD subtractor. Computes D = A - B one decimal digit
//   per clock, least-significant digit first, carrying a decimal borrow.
//   When A < B the result is the ten's complement (A - B + 10^DIGITS) and
//   o_bout is set. Any operand digit above 9 sets o_err and forces D/Bout to 0.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      synchronous active-low reset
//   i_in_valid   operand pair valid
//   o_in_ready   block can accept operands (IDLE only)
//   i_a, i_b     minuend / subtrahend, packed BCD, digit 0 in bits [3:0]
//   o_out_valid  result valid
//   i_out_ready  consumer accepts result
//   o_d          difference, packed BCD
//   o_bout       final decimal borrow (A < B)
//   o_err        an operand digit was illegal (> 9)
// -----------------------------------------------------------------------------
module bcd_sub_serial #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [4*DIGITS-1:0]   i_a,
    input  logic [4*DIGITS-1:0]   i_b,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [4*DIGITS-1:0]   o_d,
    output logic                  o_bout,
    output logic                  o_err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic            w_accept;
    logic            w_last;

    // Working operands shift right one digit per CALC cycle so the current
    // digit is always in bits [3:0].
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_diff;
    logic [IW-1:0]   r_idx;
    logic            r_borrow;
    logic            r_bad;

    logic            r_in_ready;
    logic            r_out_valid;
    logic [W-1:0]    r_d;
    logic            r_bout;
    logic            r_err;

    logic            w_bad;
    logic [4:0]      w_t;
    logic            w_neg;
    logic [3:0]      w_d;
    logic [W-1:0]    w_diff_next;

    // Illegal-digit check on the incoming operands.
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (i_a[4*i +: 4] > 4'd9 || i_b[4*i +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end

    // One decimal digit of subtraction; 5-bit two's complement covers -16..15.
    always_comb begin
        w_t   = {1'b0, r_a[3:0]} - {1'b0, r_b[3:0]} - {4'b0000, r_borrow};
        w_neg = w_t[4];
        // Low nibble of (t + 10) mod 16 equals t + 10 for t in -10..-1.
        w_d   = w_neg ? (w_t[3:0] + 4'd10) : w_t[3:0];
        // New digit enters at the top; after DIGITS shifts digit 0 is at the bottom.
        w_diff_next = (r_diff >> 4) | (W'(w_d) << (W - 4));
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_in_valid && r_in_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = StCalc;
                end
            end
            StCalc: begin
                if (r_idx == IW'(DIGITS - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (i_out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_idx       <= '0;
            r_borrow    <= 1'b0;
            r_bad       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_d         <= '0;
            r_bout      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            // Handshake flags track the state being entered so they are registered.
            r_in_ready  <= (w_state_next == StIdle);
            r_out_valid <= (w_state_next == StDone);

            if (w_accept) begin
                r_a      <= i_a;
                r_b      <= i_b;
                r_diff   <= '0;
                r_idx    <= '0;
                r_borrow <= 1'b0;
                r_bad    <= w_bad;
            end else if (r_state == StCalc) begin
                r_a      <= r_a >> 4;
                r_b      <= r_b >> 4;
                r_diff   <= w_diff_next;
                r_idx    <= r_idx + IW'(1);
                r_borrow <= w_neg;
            end

            // Result registers are loaded once and then held through DONE.
            if (w_last) begin
                r_d    <= r_bad ? '0 : w_diff_next;
                r_bout <= r_bad ? 1'b0 : w_neg;
                r_err  <= r_bad;
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_d         = r_d;
    assign o_bout      = r_bout;
    assign o_err       = r_err;

endmodule

// File: doc/bcd_sub_serial.md
# bcd_sub_serial

Digit-serial packed-BCD subtractor that computes A − B one decimal digit per clock, least-significant digit first, with a decimal borrow chain. It complements the combinational two-digit BCD adder and gives the datapath a subtract path for packed-BCD operands. Operands are taken and results returned through a valid/ready handshake on each side. Illegal BCD digits are detected and reported.

## Interface
- DIGITS, 2, number of BCD digits per operand (≥1); operand width W = 4*DIGITS
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  operand pair A/B is valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- A  input  W  minuend, packed BCD, digit 0 in A[3:0]
- B  input  W  subtrahend, packed BCD
- out_valid  output  1  D/Bout/err are valid
- out_ready  input  1  consumer accepts result
- D  output  W  difference, packed BCD
- Bout  output  1  final decimal borrow (1 when A < B)
- err  output  1  at least one digit of A or B was > 9

## Operation
- FSM states: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: register A and B, clear the borrow and digit index, load the err flag from the digit check, go to CALC.
- CALC:
  - Per cycle, for digit i (0 up to DIGITS−1): t = a_i − b_i − borrow, using signed 5-bit arithmetic.
  - If t < 0: d_i = t + 10 and borrow = 1. Otherwise d_i = t and borrow = 0.
  - d_i is written into D[4i+3:4i].
  - After digit DIGITS−1 is processed: Bout = borrow, go to DONE.
- DONE:
  - out_valid = 1. D, Bout and err are held stable until out_ready is high.
  - On out_ready: go to IDLE.
- Result encoding:
  - When Bout = 0, D = A − B.
  - When Bout = 1, D = A − B + 10^DIGITS (ten's complement). Example: 17 − 45 gives D = 72, Bout = 1.
- Illegal digits:
  - Digit check: any 4-bit digit of A or B greater than 9.
  - If the check fails, err = 1 and the block still runs through CALC. In DONE it presents D = 0 and Bout = 0.
- Inputs A/B are sampled only at acceptance. Later changes have no effect on an operation in flight.
- in_valid is ignored outside IDLE. No operand is buffered.
- Outputs are registered. No combinational path from any input to any output.

## Timing
- Reset values: in_ready = 0 during reset, then 1 from the first cycle after reset deasserts. out_valid = 0, D = 0, Bout = 0, err = 0.
- Latency:
  - Acceptance happens at clock edge 0.
  - CALC processes one digit on each of edges 1..DIGITS.
  - out_valid is high starting the cycle after edge DIGITS.
  - For DIGITS = 2: out_valid is high 2 cycles after the acceptance cycle.
- out_valid deasserts on the edge where out_valid && out_ready. in_ready reasserts on that same edge.
- Minimum initiation interval: DIGITS + 2 cycles (accept, DIGITS × CALC, DONE with out_ready already high).
- Backpressure: out_ready low holds DONE indefinitely with the outputs unchanged.
- out_ready high in IDLE or CALC has no effect.
- Reset mid-operation: rst_n low on any edge returns the block to IDLE and zeroes all outputs. The in-flight result is discarded and no out_valid pulse appears.
- Boundaries:
  - 00 − 00 gives D = 00, Bout = 0.
  - 00 − 99 gives D = 01, Bout = 1.
  - 99 − 00 gives D = 99, Bout = 0.
  - A borrow ripples correctly through a zero digit: 100 − 1 with DIGITS = 3 gives 099.

## Test plan
- DIGITS = 2, A = 0x45, B = 0x17, out_ready held 1 → out_valid exactly 2 cycles after acceptance, D = 0x28, Bout = 0, err = 0. The next acceptance is possible 4 cycles after the first.
- A = 0x17, B = 0x45 → D = 0x72, Bout = 1. A = 0x90, B = 0x09 → D = 0x81, Bout = 0. A = 0x00, B = 0x99 → D = 0x01, Bout = 1.
- A = 0x3A, B = 0x12 → err = 1, D = 0x00, Bout = 0. A = 0x50, B = 0xF0 → err = 1.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE while A/B/in_valid toggle randomly → D/Bout stable, in_ready = 0, no new acceptance. Release out_ready → one handshake, then in_ready = 1.
- Reset mid-op: assert rst_n = 0 one cycle after accepting 0x45 − 0x17 → all outputs 0, in_ready = 1 after release, no out_valid. The next operation 0x99 − 0x99 returns D = 0x00, Bout = 0.
- DIGITS = 3: A = 0x100, B = 0x001 → D = 0x099, Bout = 0, latency 3 cycles. Random legal BCD operands are compared against a decimal reference model.
